// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int LINE_BYTES = 8;  // bytes per instruction-memory line
  localparam int INST_BYTES = 4;  // bytes per instruction word

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SPLIT_LO,
    SPLIT_HI,
    HALT
  } fetch_state_t;

  // One decoded-side FIFO entry: an instruction word and the PC it lives at.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } inst_entry_t;

  // Address of the memory line that contains pc.
  function automatic logic [63:0] line_base(input logic [63:0] pc);
    return pc & ~64'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction FIFO between the fetch FSM and the decoder. Power-of-2 depth,
// registered output (no push-to-pop bypass), occupancy exported for the
// free-slot check that gates new memory requests.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  inst_entry_t              push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output inst_entry_t              head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  inst_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  // Pointer and occupancy update; a push into a full FIFO is legal only when a pop frees a slot.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control registers; cleared on reset so the FIFO restarts empty.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count guards every read, so stale entries are never seen.
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: reads 64-bit lines from instruction memory, splits each into
// two 32-bit instructions (low word first) tagged with their PCs, and hands
// them to the decoder through inst_fifo. One request outstanding at a time;
// a request is only raised while the FIFO has room for a whole line.
// Build option FETCH_HALT_ON_ZERO_EN: an all-zero word stops fetching
// (word dropped, FSM parks in HALT, halted=1, FIFO still drains).
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] entry_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [63:0] inst_pc,
  output logic        busy,
  output logic        halted
);

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_ON_ZERO = 1'b1;
`else
  localparam bit HALT_ON_ZERO = 1'b0;
`endif

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [63:0]       fetch_pc_q, fetch_pc_d;
  logic [63:0]       line_q, line_d;
  logic [63:0]       base_pc;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  free_slots;
  logic              push;
  inst_entry_t       push_entry;
  inst_entry_t       head_entry;

  assign base_pc    = line_base(fetch_pc_q);
  assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;

  // Next-state, request and push logic for the fetch FSM.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    line_d          = line_q;
    mem_req_valid   = 1'b0;
    push            = 1'b0;
    push_entry.pc   = base_pc;
    push_entry.word = line_q[31:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          fetch_pc_d = entry_pc;
          state_d    = REQ;
        end
      end
      REQ: begin
        // Both words of the line must fit before asking, so SPLIT_* never sees a full FIFO.
        mem_req_valid = (free_slots >= CNT_W'(2));
        if (mem_req_valid && mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          line_d  = mem_resp_data;
          // An entry PC in the upper half of a line skips the low word.
          state_d = fetch_pc_q[2] ? SPLIT_HI : SPLIT_LO;
        end
      end
      SPLIT_LO: begin
        if (HALT_ON_ZERO && (line_q[31:0] == 32'h0)) begin
          state_d = HALT;
        end else begin
          push    = 1'b1;
          state_d = SPLIT_HI;
        end
      end
      SPLIT_HI: begin
        push_entry.pc   = base_pc + 64'(INST_BYTES);
        push_entry.word = line_q[63:32];
        if (HALT_ON_ZERO && (line_q[63:32] == 32'h0)) begin
          state_d = HALT;
        end else begin
          push       = 1'b1;
          fetch_pc_d = base_pc + 64'(LINE_BYTES);  // wraps modulo 2^64
          state_d    = REQ;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // FSM, fetch PC and line registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      line_q     <= line_d;
    end
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (inst_ready),
    .head_valid (inst_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign inst_word    = head_entry.word;
  assign inst_pc      = head_entry.pc;
  assign mem_req_addr = base_pc;
  assign busy         = (state_q != IDLE) && (state_q != HALT);
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a memory responder, a queue-based
// model of the expected instruction stream, a per-cycle compare process and
// directed scenarios with literal expectations.
module tb_inst_fetch_unit;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_MODE = 1'b1;
`else
  localparam bit HALT_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] entry_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        busy;
  logic        halted;

  inst_fetch_unit #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .entry_pc       (entry_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .busy           (busy),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_addr   = '0;
  bit          skip_lo    = 1'b0;
  bit          model_halt = 1'b0;
  int          lat        = 1;
  bit          manual     = 1'b0;
  int          resp_cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: two fixed lines, everything else derived from the address.
  function automatic logic [63:0] line_at(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    case (a)
      64'h1000: return 64'h00100093_00000513;
      64'h2000: return 64'h00000000_00a00513;
      default:  return {(lo + 32'h4) ^ 32'hA500_0000, lo ^ 32'h5A00_0000};
    endcase
  endfunction

  // Expected stream for one returned line.
  task automatic model_line(input logic [63:0] a, input logic [63:0] d);
    logic [31:0] word;
    if (model_halt) return;
    for (int w = 0; w < 2; w++) begin
      word = (w == 0) ? d[31:0] : d[63:32];
      if (!(w == 0 && skip_lo)) begin
        if (HALT_MODE && word == 32'h0) begin
          model_halt = 1'b1;
          return;
        end
        exp_q.push_back('{pc: a + 64'(4 * w), word: word});
      end
    end
    skip_lo  = 1'b0;
    exp_addr = a + 64'd8;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: accepts on valid&&ready, answers lat cycles later.
  initial begin : mem_model
    bit          pend;
    int          cnt;
    logic [63:0] paddr;
    pend = 1'b0;
    cnt  = 0;
    paddr = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_req_valid && mem_req_ready) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = mem_req_addr;
      end
      @(posedge clk);
      #1;
      if (reset || manual) pend = 1'b0;
      if (!manual) begin
        mem_resp_valid = 1'b0;
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            pend           = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = line_at(paddr);
            resp_cyc       = cyc;
            model_line(paddr, mem_resp_data);
          end
        end
      end
    end
  end

  // Per-cycle comparison of the decoder interface and request address against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req_valid) check("req_addr", mem_req_addr, exp_addr);
        if (model_halt) check("halt_no_req", {63'b0, mem_req_valid}, 64'd0);
        if (inst_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_inst", {63'b0, inst_valid}, 64'd0);
          end else begin
            check("inst_pc", inst_pc, exp_q[0].pc);
            check("inst_word", {32'b0, inst_word}, {32'b0, exp_q[0].word});
            if (inst_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_ivalid"}, {63'b0, inst_valid}, 64'd0);
    check({name, "_iword"}, {32'b0, inst_word}, 64'd0);
    check({name, "_ipc"}, inst_pc, 64'd0);
    check({name, "_rvalid"}, {63'b0, mem_req_valid}, 64'd0);
    check({name, "_raddr"}, mem_req_addr, 64'd0);
    check({name, "_busy"}, {63'b0, busy}, 64'd0);
    check({name, "_halted"}, {63'b0, halted}, 64'd0);
  endtask

  task automatic reset_dut();
    tick(1);
    reset         = 1'b1;
    start         = 1'b0;
    entry_pc      = '0;
    inst_ready    = 1'b1;
    mem_req_ready = 1'b1;
    lat           = 1;
    manual        = 1'b0;
    exp_q.delete();
    model_halt    = 1'b0;
    skip_lo       = 1'b0;
    exp_addr      = '0;
    tick(2);
    check_idle("rst");
    reset = 1'b0;
    tick(1);
  endtask

  task automatic do_start(input logic [63:0] pc);
    exp_addr = pc & ~64'h7;
    skip_lo  = pc[2];
    entry_pc = pc;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic wait_inst(input string name);
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) return;
      @(negedge clk);
    end
    check({name, "_timeout"}, {63'b0, inst_valid}, 64'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40; i++) begin
      if (mem_req_valid) return;
      @(negedge clk);
    end
    check({name, "_timeout"}, {63'b0, mem_req_valid}, 64'd1);
  endtask

  initial begin : stimulus
    reset          = 1'b1;
    start          = 1'b0;
    entry_pc       = '0;
    inst_ready     = 1'b1;
    mem_req_ready  = 1'b1;
    #2;
    check_idle("por");

    // 1: aligned entry, both words, latency, next line address.
    reset_dut();
    do_start(64'h1000);
    wait_inst("t1_inst");
    check("t1_latency", 64'(cyc - resp_cyc), 64'd2);
    check("t1_pc0", inst_pc, 64'h1000);
    check("t1_w0", {32'b0, inst_word}, 64'h0000_0513);
    @(negedge clk);
    check("t1_pc1", inst_pc, 64'h1004);
    check("t1_w1", {32'b0, inst_word}, 64'h0010_0093);
    wait_req("t1_req");
    check("t1_next_addr", mem_req_addr, 64'h1008);

    // 2: entry in upper half of line skips the low word.
    reset_dut();
    do_start(64'h1004);
    wait_req("t2_req");
    check("t2_addr", mem_req_addr, 64'h1000);
    @(negedge clk);
    wait_inst("t2_inst");
    check("t2_pc", inst_pc, 64'h1004);
    check("t2_w", {32'b0, inst_word}, 64'h0010_0093);
    wait_req("t2_req2");
    check("t2_next_addr", mem_req_addr, 64'h1008);

    // 3: decoder stalled, FIFO fills and requests stop; release drains in order.
    reset_dut();
    inst_ready = 1'b0;
    do_start(64'h3000);
    tick(20);
    check("t3_stall_req", {63'b0, mem_req_valid}, 64'd0);
    check("t3_head_valid", {63'b0, inst_valid}, 64'd1);
    check("t3_head_pc", inst_pc, 64'h3000);
    check("t3_busy", {63'b0, busy}, 64'd1);
    inst_ready = 1'b1;
    tick(30);

    // 4: line with a zero high word.
    reset_dut();
    do_start(64'h2000);
    wait_inst("t4_inst");
    check("t4_pc0", inst_pc, 64'h2000);
    check("t4_w0", {32'b0, inst_word}, 64'h00a0_0513);
`ifdef FETCH_HALT_ON_ZERO_EN
    tick(6);
    check("t4_halted", {63'b0, halted}, 64'd1);
    check("t4_busy", {63'b0, busy}, 64'd0);
    check("t4_no_req", {63'b0, mem_req_valid}, 64'd0);
    check("t4_drained", {63'b0, inst_valid}, 64'd0);
    do_start(64'h5000);
    tick(4);
    check("t4_start_ignored", {63'b0, halted}, 64'd1);
`else
    @(negedge clk);
    check("t4_pc1", inst_pc, 64'h2004);
    check("t4_w1", {32'b0, inst_word}, 64'h0);
    wait_req("t4_req");
    check("t4_next_addr", mem_req_addr, 64'h2008);
    check("t4_halted", {63'b0, halted}, 64'd0);
`endif

    // 5: reset during WAIT, late response ignored.
    reset_dut();
    lat = 10;
    do_start(64'h4000);
    wait_req("t5_req");
    tick(2);
    manual = 1'b1;
    check("t5_in_wait_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_idle("t5_rst");
    tick(1);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = line_at(64'h4000);
    tick(1);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_idle("t5_after");
    end

    // 6: top-of-memory line, request held under back-pressure, address wraps.
    reset_dut();
    mem_req_ready = 1'b0;
    lat = 2;
    do_start(64'hFFFF_FFFF_FFFF_FFF8);
    wait_req("t6_req");
    check("t6_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t6_hold_valid", {63'b0, mem_req_valid}, 64'd1);
      check("t6_hold_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    end
    mem_req_ready = 1'b1;
    wait_inst("t6_inst");
    check("t6_pc0", inst_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    check("t6_w0", {32'b0, inst_word}, 64'hA5FF_FFF8);
    @(negedge clk);
    check("t6_pc1", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_w1", {32'b0, inst_word}, 64'h5AFF_FFFC);
    wait_req("t6_req2");
    check("t6_wrap_addr", mem_req_addr, 64'h0);
    tick(10);

    reset_dut();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
